microcode_sequencer: RTL and testbench
======================================

Name: microcode_sequencer

Overview:
- Parametrised microcode next-address sequencer for the m68000 core and successor cores.
- Generalises fixed 9-bit / 3-entry-stack branching to configurable address width, stack depth and condition count.
- Adds a hardware loop counter, dispatch-with-continuation, hold, and sticky stack overflow/underflow reporting.
- Sits between the microcode ROM (synchronous read, addressed by micro_pc) and the datapath/decoder condition sources.

Parameters:
- ADDR_W, 9: microcode address width.
- STACK_DEPTH, 4: return-stack entries (>=1).
- NUM_COND, 16: number of condition inputs.
- CSEL_W, 4: condition select width; must equal clog2(NUM_COND).
- CNT_W, 6: loop counter width (<= ADDR_W).
- RESET_ADDR, 0: address after reset.
- UNDERFLOW_ADDR, 1: target of RETURN on an empty stack.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- op  in  3  sequencer opcode from the current microword
- cond_sel  in  CSEL_W  selects cond[cond_sel]
- cond_pol  in  1  1 = act when the selected condition is 1; 0 = act when it is 0
- cond  in  NUM_COND  condition vector
- target  in  ADDR_W  branch / call / loop target or load value from the microword
- dispatch_addr  in  ADDR_W  decoder entry address
- dispatch_valid  in  1  decoder entry address valid
- trap_req  in  1  forced jump request (bus or address error)
- trap_addr  in  ADDR_W  trap entry address
- hold  in  1  freeze sequencer this cycle
- clear_flags  in  1  clears the sticky flags
- micro_pc  out  ADDR_W  next address, combinational, drives the ROM
- micro_pc_q  out  ADDR_W  current address, registered
- stack_level  out  clog2(STACK_DEPTH+1)  occupied stack entries
- loop_zero  out  1  loop counter == 0
- stack_overflow  out  1  sticky overflow flag
- stack_underflow  out  1  sticky underflow flag

Behaviour:
- Definitions:
  - c = (cond[cond_sel] == cond_pol).
  - inc = micro_pc_q + 1, modulo 2^ADDR_W; RESET_ADDR..max wraps to 0.
- Update rule: micro_pc_q <= micro_pc every cycle.
- Next-address priority:
  - reset_n low: micro_pc = RESET_ADDR.
  - else trap_req: micro_pc = trap_addr; stack and counter unchanged.
  - else hold: micro_pc = micro_pc_q; no state change; flags may still clear.
  - else decode op, as below.
- Opcodes:
  - 0 NEXT: inc.
  - 1 JUMP: c ? target : inc.
  - 2 CALL: if c, micro_pc = target and push inc; else inc.
  - 3 RETURN: stack non-empty -> top, pop. Empty -> UNDERFLOW_ADDR; set stack_underflow; stack unchanged.
  - 4 DISPATCH: dispatch_valid ? dispatch_addr with push of target (continuation) : micro_pc_q (wait).
  - 5 WAIT: c ? inc : micro_pc_q.
  - 6 LOAD_CNT: counter <= target[CNT_W-1:0]; micro_pc = inc.
  - 7 LOOP: counter != 0 -> counter - 1 and jump to target. Counter == 0 -> inc, counter stays 0. A load of N executes the loop body N+1 times.
- Stack:
  - Shift-register organisation; entry 0 is the top.
  - Push shifts down. When stack_level == STACK_DEPTH, the deepest entry is discarded, stack_level stays at STACK_DEPTH, and stack_overflow is set.
  - Pop shifts up and fills the deepest entry with 0.
- Sticky flags:
  - Cleared by reset or clear_flags.
  - If a set event and clear_flags occur in the same cycle, set wins.
- Reset values:
  - micro_pc_q = RESET_ADDR, counter = 0, all stack entries = 0, stack_level = 0, both flags = 0.
  - loop_zero = 1.
  - micro_pc = RESET_ADDR while reset_n is low.
- Reset mid-operation (e.g. during a DISPATCH wait or a loop) abandons all state on the next clock edge; no partial push or pop survives.
- Unused cond_sel values beyond NUM_COND-1 read as 0.

Test Plan:
- Reset then NEXT x3 from RESET_ADDR=0: micro_pc_q = 0,1,2,3. Then JUMP with c=1, target=0x1FF, then NEXT: micro_pc_q = 0x1FF then 0x000 (wrap).
- Nested CALLs at 0x010 -> 0x100, 0x101 -> 0x180, 0x181 -> 0x1C0, then 3 RETURNs: stack_level = 3; returns go to 0x182, 0x102, 0x011; stack_level = 0; no flags set.
- Overflow and underflow:
  - STACK_DEPTH=4, 5 CALLs: stack_overflow = 1, stack_level = 4, first return address lost.
  - 5 RETURNs: fifth goes to UNDERFLOW_ADDR and sets stack_underflow.
  - clear_flags clears both flags.
- LOAD_CNT target=3, body at 0x040, LOOP at 0x041 targeting 0x040: body executes 4 times, then micro_pc_q = 0x042, loop_zero = 1.
- DISPATCH with target=0x020 and dispatch_valid low for 3 cycles, then high with dispatch_addr=0x0A5:
  - micro_pc holds for 3 cycles, then 0x0A5; stack top = 0x020.
  - A later RETURN goes to 0x020.
- trap_req asserted together with hold, and separately together with CALL (c=1): micro_pc = trap_addr both times; stack_level unchanged.
- reset_n low during a LOOP with counter = 5: next cycle micro_pc_q = RESET_ADDR, counter = 0, stack empty.

Source files
------------

// File: rtl/microcode_sequencer.sv
// Microcode next-address sequencer: condition branching, call/return stack,
// hardware loop counter, dispatch with continuation, trap and hold.
module microcode_sequencer #(
    parameter int ADDR_W         = 9,
    parameter int STACK_DEPTH    = 4,
    parameter int NUM_COND       = 16,
    parameter int CSEL_W         = 4,
    parameter int CNT_W          = 6,
    parameter int RESET_ADDR     = 0,
    parameter int UNDERFLOW_ADDR = 1
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [2:0]                         op,
    input  logic [CSEL_W-1:0]                  cond_sel,
    input  logic                               cond_pol,
    input  logic [NUM_COND-1:0]                cond,
    input  logic [ADDR_W-1:0]                  target,
    input  logic [ADDR_W-1:0]                  dispatch_addr,
    input  logic                               dispatch_valid,
    input  logic                               trap_req,
    input  logic [ADDR_W-1:0]                  trap_addr,
    input  logic                               hold,
    input  logic                               clear_flags,
    output logic [ADDR_W-1:0]                  micro_pc,
    output logic [ADDR_W-1:0]                  micro_pc_q,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
    output logic                               loop_zero,
    output logic                               stack_overflow,
    output logic                               stack_underflow
);

    localparam int LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SEL_N = 1 << CSEL_W;

    localparam logic [2:0] OP_NEXT     = 3'd0;
    localparam logic [2:0] OP_JUMP     = 3'd1;
    localparam logic [2:0] OP_CALL     = 3'd2;
    localparam logic [2:0] OP_RETURN   = 3'd3;
    localparam logic [2:0] OP_DISPATCH = 3'd4;
    localparam logic [2:0] OP_WAIT     = 3'd5;
    localparam logic [2:0] OP_LOAD_CNT = 3'd6;
    localparam logic [2:0] OP_LOOP     = 3'd7;

    localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_ADDR);
    localparam logic [ADDR_W-1:0] UNF_PC   = ADDR_W'(UNDERFLOW_ADDR);
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [CNT_W-1:0]  counter;
    logic [SEL_N-1:0]  cond_ext;
    logic              c;
    logic [ADDR_W-1:0] inc;
    logic              stack_full;
    logic              stack_empty;
    logic              do_push;
    logic              do_pop;
    logic [ADDR_W-1:0] push_val;
    logic              cnt_load;
    logic              cnt_dec;
    logic              set_ovf;
    logic              set_unf;

    // Zero-extending the condition vector makes out-of-range selects read as 0
    assign cond_ext    = SEL_N'(cond);
    assign c           = (cond_ext[cond_sel] == cond_pol);
    assign inc         = micro_pc_q + ADDR_W'(1);
    assign stack_full  = (stack_level == FULL_LVL);
    assign stack_empty = (stack_level == '0);
    assign loop_zero   = (counter == '0);

    // Next-address selection and stack/counter/flag update requests
    always_comb begin
        micro_pc = inc;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        push_val = '0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        set_unf  = 1'b0;
        if (!reset_n) begin
            micro_pc = RST_PC;
        end else if (trap_req) begin
            micro_pc = trap_addr;
        end else if (hold) begin
            micro_pc = micro_pc_q;
        end else begin
            case (op)
                OP_NEXT: micro_pc = inc;
                OP_JUMP: micro_pc = c ? target : inc;
                OP_CALL: begin
                    if (c) begin
                        micro_pc = target;
                        do_push  = 1'b1;
                        push_val = inc;
                    end
                end
                OP_RETURN: begin
                    if (stack_empty) begin
                        micro_pc = UNF_PC;
                        set_unf  = 1'b1;
                    end else begin
                        micro_pc = stack[0];
                        do_pop   = 1'b1;
                    end
                end
                OP_DISPATCH: begin
                    if (dispatch_valid) begin
                        micro_pc = dispatch_addr;
                        do_push  = 1'b1;
                        push_val = target;
                    end else begin
                        micro_pc = micro_pc_q;
                    end
                end
                OP_WAIT: micro_pc = c ? inc : micro_pc_q;
                OP_LOAD_CNT: begin
                    micro_pc = inc;
                    cnt_load = 1'b1;
                end
                OP_LOOP: begin
                    if (!loop_zero) begin
                        micro_pc = target;
                        cnt_dec  = 1'b1;
                    end
                end
                default: micro_pc = inc;
            endcase
        end
        set_ovf = do_push & stack_full;
    end

    // Address register and loop counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            micro_pc_q <= RST_PC;
            counter    <= '0;
        end else begin
            micro_pc_q <= micro_pc;
            if (cnt_load) begin
                counter <= target[CNT_W-1:0];
            end else if (cnt_dec) begin
                counter <= counter - CNT_W'(1);
            end
        end
    end

    // Shift-register return stack; entry 0 is the top, a full push drops the deepest entry
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                stack[i[IDX_W-1:0]] <= '0;
            end
            stack_level <= '0;
        end else if (do_push) begin
            stack[0] <= push_val;
            for (int unsigned i = 1; i < STACK_DEPTH; i++) begin
                stack[i[IDX_W-1:0]] <= stack[IDX_W'(i - 1)];
            end
            if (!stack_full) begin
                stack_level <= stack_level + LVL_W'(1);
            end
        end else if (do_pop) begin
            for (int unsigned i = 0; i + 1 < STACK_DEPTH; i++) begin
                stack[i[IDX_W-1:0]] <= stack[IDX_W'(i + 1)];
            end
            stack[STACK_DEPTH-1] <= '0;
            stack_level <= stack_level - LVL_W'(1);
        end
    end

    // Sticky error flags; a set event wins over a simultaneous clear
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            stack_overflow  <= set_ovf | (stack_overflow  & ~clear_flags);
            stack_underflow <= set_unf | (stack_underflow & ~clear_flags);
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed self-checking bench for microcode_sequencer (default parameters).
module tb_microcode_sequencer;

    localparam logic [2:0] OP_NEXT     = 3'd0;
    localparam logic [2:0] OP_JUMP     = 3'd1;
    localparam logic [2:0] OP_CALL     = 3'd2;
    localparam logic [2:0] OP_RETURN   = 3'd3;
    localparam logic [2:0] OP_DISPATCH = 3'd4;
    localparam logic [2:0] OP_WAIT     = 3'd5;
    localparam logic [2:0] OP_LOAD_CNT = 3'd6;
    localparam logic [2:0] OP_LOOP     = 3'd7;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  op;
    logic [3:0]  cond_sel;
    logic        cond_pol;
    logic [15:0] cond;
    logic [8:0]  target;
    logic [8:0]  dispatch_addr;
    logic        dispatch_valid;
    logic        trap_req;
    logic [8:0]  trap_addr;
    logic        hold;
    logic        clear_flags;
    logic [8:0]  micro_pc;
    logic [8:0]  micro_pc_q;
    logic [2:0]  stack_level;
    logic        loop_zero;
    logic        stack_overflow;
    logic        stack_underflow;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned body_cnt;

    microcode_sequencer #(
        .ADDR_W(9),
        .STACK_DEPTH(4),
        .NUM_COND(16),
        .CSEL_W(4),
        .CNT_W(6),
        .RESET_ADDR(0),
        .UNDERFLOW_ADDR(1)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .op(op),
        .cond_sel(cond_sel),
        .cond_pol(cond_pol),
        .cond(cond),
        .target(target),
        .dispatch_addr(dispatch_addr),
        .dispatch_valid(dispatch_valid),
        .trap_req(trap_req),
        .trap_addr(trap_addr),
        .hold(hold),
        .clear_flags(clear_flags),
        .micro_pc(micro_pc),
        .micro_pc_q(micro_pc_q),
        .stack_level(stack_level),
        .loop_zero(loop_zero),
        .stack_overflow(stack_overflow),
        .stack_underflow(stack_underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_c(input logic v);
        cond_sel = 4'd5;
        cond_pol = 1'b1;
        cond     = '0;
        cond[5]  = v;
    endtask

    initial begin
        reset_n = 1'b0; op = OP_NEXT; cond_sel = '0; cond_pol = 1'b1; cond = '0;
        target = '0; dispatch_addr = '0; dispatch_valid = 1'b0; trap_req = 1'b0;
        trap_addr = '0; hold = 1'b0; clear_flags = 1'b0;
        step(); step();
        check("rst_pc",     micro_pc, 32'h0);
        check("rst_pc_q",   micro_pc_q, 32'h0);
        check("rst_level",  stack_level, 32'd0);
        check("rst_lzero",  loop_zero, 32'd1);
        check("rst_ovf",    stack_overflow, 32'd0);
        check("rst_unf",    stack_underflow, 32'd0);

        // NEXT x3
        reset_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("next_seq", micro_pc_q, k);
        end

        // JUMP taken to top of space, NEXT wraps, JUMP not taken
        op = OP_JUMP; set_c(1'b1); target = 9'h1FF;
        step(); check("jump_taken", micro_pc_q, 32'h1FF);
        op = OP_NEXT;
        step(); check("next_wrap", micro_pc_q, 32'h000);
        op = OP_JUMP; set_c(1'b0); target = 9'h0AA;
        step(); check("jump_not_taken", micro_pc_q, 32'h001);

        // Nested calls
        op = OP_JUMP; set_c(1'b1); target = 9'h010; step();
        op = OP_CALL; target = 9'h100; step();
        check("call1", micro_pc_q, 32'h100);
        op = OP_NEXT; step();
        op = OP_CALL; target = 9'h180; step();
        op = OP_NEXT; step();
        op = OP_CALL; target = 9'h1C0; step();
        check("call3", micro_pc_q, 32'h1C0);
        check("nest_level3", stack_level, 32'd3);
        op = OP_RETURN;
        step(); check("ret1", micro_pc_q, 32'h182);
        step(); check("ret2", micro_pc_q, 32'h102);
        step(); check("ret3", micro_pc_q, 32'h011);
        check("nest_level0", stack_level, 32'd0);
        check("nest_ovf",    stack_overflow, 32'd0);
        check("nest_unf",    stack_underflow, 32'd0);

        // Overflow: 5 calls into a 4-deep stack
        op = OP_CALL;
        for (int k = 0; k < 5; k++) begin
            target = 9'h050 + 9'(k * 16);
            step();
            if (k == 3) check("ovf_not_yet", stack_overflow, 32'd0);
        end
        check("ovf_set",   stack_overflow, 32'd1);
        check("ovf_level", stack_level, 32'd4);
        op = OP_RETURN;
        step(); check("oret1", micro_pc_q, 32'h081);
        step(); check("oret2", micro_pc_q, 32'h071);
        step(); check("oret3", micro_pc_q, 32'h061);
        step(); check("oret4", micro_pc_q, 32'h051);
        check("unf_not_yet", stack_underflow, 32'd0);
        step(); check("oret5_unf_addr", micro_pc_q, 32'h001);
        check("unf_set",   stack_underflow, 32'd1);
        check("unf_level", stack_level, 32'd0);
        check("ovf_sticky", stack_overflow, 32'd1);
        op = OP_NEXT; clear_flags = 1'b1;
        step();
        check("clr_ovf", stack_overflow, 32'd0);
        check("clr_unf", stack_underflow, 32'd0);
        // set beats clear in the same cycle
        op = OP_RETURN;
        step(); check("set_wins_unf", stack_underflow, 32'd1);
        op = OP_NEXT;
        step(); check("clr_again", stack_underflow, 32'd0);
        clear_flags = 1'b0;

        // Loop: LOAD_CNT 3, body at 0x040, LOOP at 0x041
        op = OP_JUMP; set_c(1'b1); target = 9'h03F; step();
        op = OP_LOAD_CNT; target = 9'd3; step();
        check("load_pc",    micro_pc_q, 32'h040);
        check("load_lzero", loop_zero, 32'd0);
        body_cnt = 0;
        for (int k = 0; k < 40 && micro_pc_q != 9'h042; k++) begin
            if (micro_pc_q == 9'h040) begin
                body_cnt++;
                op = OP_NEXT;
            end else begin
                op = OP_LOOP;
                target = 9'h040;
            end
            step();
        end
        check("loop_body_count", body_cnt, 32'd4);
        check("loop_exit_pc",    micro_pc_q, 32'h042);
        check("loop_exit_lzero", loop_zero, 32'd1);

        // Dispatch wait then accept
        op = OP_DISPATCH; target = 9'h020; dispatch_valid = 1'b0; dispatch_addr = 9'h0A5;
        for (int k = 0; k < 3; k++) begin
            #1 check("disp_wait_pc", micro_pc, 32'h042);
            step();
            check("disp_wait_q", micro_pc_q, 32'h042);
        end
        dispatch_valid = 1'b1;
        #1 check("disp_pc", micro_pc, 32'h0A5);
        step();
        check("disp_q",     micro_pc_q, 32'h0A5);
        check("disp_level", stack_level, 32'd1);
        dispatch_valid = 1'b0;
        op = OP_RETURN;
        step(); check("disp_cont", micro_pc_q, 32'h020);

        // Trap with hold, trap with taken CALL
        op = OP_CALL; set_c(1'b1); target = 9'h070; step();
        check("pre_trap_level", stack_level, 32'd1);
        trap_req = 1'b1; hold = 1'b1; trap_addr = 9'h155;
        #1 check("trap_hold_pc", micro_pc, 32'h155);
        step();
        check("trap_hold_q",     micro_pc_q, 32'h155);
        check("trap_hold_level", stack_level, 32'd1);
        trap_req = 1'b0;
        #1 check("hold_pc", micro_pc, 32'h155);
        step(); check("hold_q", micro_pc_q, 32'h155);
        hold = 1'b0; trap_req = 1'b1; trap_addr = 9'h1AB; target = 9'h0AA;
        #1 check("trap_call_pc", micro_pc, 32'h1AB);
        step();
        check("trap_call_level", stack_level, 32'd1);
        trap_req = 1'b0; op = OP_RETURN;
        step(); check("trap_stack_intact", micro_pc_q, 32'h021);

        // WAIT, and inverted polarity
        op = OP_WAIT; set_c(1'b0);
        step(); check("wait_stall", micro_pc_q, 32'h021);
        set_c(1'b1);
        step(); check("wait_go", micro_pc_q, 32'h022);
        op = OP_JUMP; set_c(1'b0); cond_pol = 1'b0; target = 9'h0F0;
        step(); check("jump_pol0", micro_pc_q, 32'h0F0);

        // Reset during a loop with counter 5 and a live stack entry
        op = OP_LOAD_CNT; target = 9'd5; step();
        op = OP_CALL; set_c(1'b1); target = 9'h0C0; step();
        check("pre_rst_level", stack_level, 32'd1);
        op = OP_LOOP; reset_n = 1'b0;
        #1 check("rst_mid_pc", micro_pc, 32'h000);
        step();
        check("rst_mid_q",     micro_pc_q, 32'h000);
        check("rst_mid_level", stack_level, 32'd0);
        check("rst_mid_lzero", loop_zero, 32'd1);
        reset_n = 1'b1; op = OP_RETURN;
        step();
        check("rst_mid_empty_ret", micro_pc_q, 32'h001);
        check("rst_mid_unf",       stack_underflow, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
